// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x WIDTH register file, one write port, two registered read ports with write-first bypass.
module regfile_2r1w #(
    parameter int WIDTH    = 8,
    parameter int NREGS    = 16,
    parameter int AW       = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [WIDTH-1:0]       wd,
    input  logic                   re_a,
    input  logic [AW-1:0]          ra_a,
    output logic [WIDTH-1:0]       rd_a,
    output logic                   rv_a,
    input  logic                   re_b,
    input  logic [AW-1:0]          ra_b,
    output logic [WIDTH-1:0]       rd_b,
    output logic                   rv_b,
    output logic                   rerr,
    output logic [NREGS*WIDTH-1:0] regs_flat
);
    localparam logic [AW:0] N = (AW+1)'(NREGS);
    logic [WIDTH-1:0] mem [NREGS];
    logic wa_ok, ra_a_ok, ra_b_ok, w_legal, w_en;
    logic [WIDTH-1:0] nxt_a, nxt_b;
    assign wa_ok   = {1'b0, wa} < N;
    assign ra_a_ok = {1'b0, ra_a} < N;
    assign ra_b_ok = {1'b0, ra_b} < N;
    assign w_legal = we && wa_ok && !(ZERO_REG != 0 && wa == '0);
    assign w_en    = w_legal && !clr;
    // Read priority: clear, out of range, zero register, bypass, storage.
    always_comb begin
        nxt_a = (clr || !ra_a_ok || (ZERO_REG != 0 && ra_a == '0)) ? '0 :
                (w_legal && wa == ra_a) ? wd : mem[ra_a];
        nxt_b = (clr || !ra_b_ok || (ZERO_REG != 0 && ra_b == '0)) ? '0 :
                (w_legal && wa == ra_b) ? wd : mem[ra_b];
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (w_en) begin
            mem[wa] <= wd;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a <= '0;
            rd_b <= '0;
            rv_a <= 1'b0;
            rv_b <= 1'b0;
            rerr <= 1'b0;
        end else begin
            rv_a <= re_a;
            rv_b <= re_b;
            if (re_a) rd_a <= nxt_a;
            if (re_b) rd_b <= nxt_b;
            rerr <= (we && !wa_ok) || (re_a && !ra_a_ok) || (re_b && !ra_b_ok);
        end
    end
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = (ZERO_REG != 0 && g == 0) ? '0 : mem[g];
    end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file: NREGS entries of WIDTH bits, one synchronous write port, two independent registered read ports (A, B).
- Successor to the byte-select read mux on the 16x8 flattened register bus. Generalised in depth and width, with a second read port, write-first bypass, read-valid signalling, bulk clear and range checking.
- Sits between the decode stage (register addresses) and the ALU operand latches. Also drives the flattened register bus for debug and display.

Parameters:
- WIDTH, 8, bits per register.
- NREGS, 16, number of registers (2..256).
- AW, 4, address width; must satisfy 2^AW >= NREGS.
- ZERO_REG, 1, when 1, register 0 is hardwired to zero: writes ignored, reads return 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous bulk clear of all registers.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- re_a  in  1  read request, port A.
- ra_a  in  AW  read address, port A.
- rd_a  out  WIDTH  read data, port A (registered).
- rv_a  out  1  read data valid, port A.
- re_b  in  1  read request, port B.
- ra_b  in  AW  read address, port B.
- rd_b  out  WIDTH  read data, port B (registered).
- rv_b  out  1  read data valid, port B.
- rerr  out  1  pulse: any enabled access used an address >= NREGS.
- regs_flat  out  NREGS*WIDTH  all registers concatenated; reg i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (rst=1 at posedge):
  - All registers, rd_a, rd_b become 0.
  - rv_a, rv_b, rerr become 0.
  - rst has priority over clr, we and re_*.
- Clear (clr=1, rst=0):
  - All registers become 0 at the edge.
  - Any write that cycle is discarded.
  - Reads enabled that cycle return 0 with rv=1.
- Write (we=1, clr=0, rst=0):
  - mem[wa] <= wd at the edge.
  - Ignored if wa >= NREGS.
  - Ignored if ZERO_REG=1 and wa=0.
- Read timing:
  - Latency is exactly 1 cycle: re_x sampled at edge N gives rd_x and rv_x=1 after edge N.
  - rv_x is a 1-cycle pulse per request; back-to-back requests give continuous rv_x=1.
- Read data priority (highest first):
  1. clr → 0.
  2. Address out of range → 0.
  3. ZERO_REG=1 and address 0 → 0.
  4. Bypass: we=1 and wa==ra_x with a legal write → wd (write-first).
  5. Otherwise mem[ra_x].
- Read idle: when re_x=0, rd_x holds its previous value and rv_x=0.
- Ports A and B are fully independent. The same address on both ports returns identical data.
- rerr:
  - Registered; 1 for one cycle after any edge where an enabled access had address >= NREGS. Enabled accesses are we, re_a, re_b.
  - Otherwise 0.
  - The access itself behaves as above: write dropped, read returns 0 with rv=1.
- regs_flat:
  - Combinational from storage; reflects writes the cycle after the edge.
  - Field 0 is constant 0 when ZERO_REG=1.
- No internal state beyond storage, rd_*, rv_* and rerr. No state machine is required beyond this pipeline register stage.

Test Plan:
- Reset with default params: rst=1 for 2 cycles, then idle → rd_a=rd_b=0, rv_*=0, regs_flat=128'h0.
- Write and read: write 8'hA5 to reg 3, next cycle re_a=1, ra_a=3 → one cycle later rd_a=8'hA5, rv_a=1; regs_flat[31:24]=8'hA5.
- Bypass: same cycle we=1, wa=7, wd=8'h3C, re_a=1, re_b=1, ra_a=ra_b=7 → next cycle rd_a=rd_b=8'h3C, both rv=1.
- Zero register: write 8'hFF to reg 0, then read reg 0 on port B → rd_b=0 and regs_flat[7:0]=0.
- Clear and range check with NREGS=12:
  - Fill regs 1..11 with i, then assert clr with we=1 to reg 5 → all regs 0 after the edge.
  - re_a with ra_a=13 → rd_a=0, rv_a=1, rerr=1 for exactly one cycle.
- Reset mid-operation: rst asserted in the same cycle as we=1 (reg 2, 8'h11) and re_a=1 → reg 2 stays 0, rv_a=0, rd_a=0.
